// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Independent safety checker on the main/cross lamp buses of a two-way
// intersection controller. It checks the lamp encoding, mutual exclusion,
// phase order and yellow duration. On any violation it latches a fault code
// and requests flashing red until an explicit clear re-arms it.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   light_main   main lamps  (100 red, 010 yellow, 001 green)
//   light_cross  cross lamps (same encoding)
//   clear        single-cycle fault acknowledge
//   fault        1 while in FAULT
//   fault_code   0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 YEL_SHORT, 5 YEL_LONG
//   flash        flashing-red request, square wave while in FAULT
//   armed        1 while in MONITOR
module traffic_conflict_monitor #(
   parameter int unsigned ARM_CYC     = 4,
   parameter int unsigned YEL_MIN_CYC = 8,
   parameter int unsigned YEL_MAX_CYC = 16,
   parameter int unsigned FLASH_DIV   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] light_main,
   input  logic [2:0] light_cross,
   input  logic       clear,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash,
   output logic       armed
);

   localparam int unsigned YCW = 16;
   localparam int unsigned ACW = $clog2(ARM_CYC + 1);
   localparam int unsigned FCW = $clog2(FLASH_DIV + 1);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [2:0] CODE_NONE      = 3'd0;
   localparam logic [2:0] CODE_ENC       = 3'd1;
   localparam logic [2:0] CODE_CONFLICT  = 3'd2;
   localparam logic [2:0] CODE_SEQ       = 3'd3;
   localparam logic [2:0] CODE_YEL_SHORT = 3'd4;
   localparam logic [2:0] CODE_YEL_LONG  = 3'd5;

   typedef enum logic [1:0] {
      ST_ARM     = 2'd0,
      ST_MONITOR = 2'd1,
      ST_FAULT   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       prev_main_q, prev_cross_q;
   logic [YCW-1:0]   ymain_q, ymain_d, ycross_q, ycross_d;
   logic [ACW-1:0]   arm_cnt_q, arm_cnt_d;
   logic [FCW-1:0]   flash_cnt_q, flash_cnt_d;
   logic             flash_q, flash_d;
   logic             fault_q, fault_d;
   logic             armed_q, armed_d;
   logic [2:0]       code_q, code_d;

   logic             enc_viol, conf_viol, seq_viol, ys_viol, yl_viol;
   logic             safe_pat, stable_pat;
   logic [2:0]       code_arm, code_mon;

   // Valid lamp value: exactly one of red/yellow/green.
   function automatic logic lamp_ok(input logic [2:0] v);
      return (v == LAMP_R) || (v == LAMP_Y) || (v == LAMP_G);
   endfunction

   // Unchanged, or one legal step green->yellow->red->green.
   function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
      return (p == c) ||
             ((p == LAMP_G) && (c == LAMP_Y)) ||
             ((p == LAMP_Y) && (c == LAMP_R)) ||
             ((p == LAMP_R) && (c == LAMP_G));
   endfunction

   // Violation detection on current inputs against the previous sample.
   always_comb begin
      enc_viol   = !lamp_ok(light_main) || !lamp_ok(light_cross);
      conf_viol  = (light_main != LAMP_R) && (light_cross != LAMP_R);
      seq_viol   = !step_ok(prev_main_q, light_main) ||
                   !step_ok(prev_cross_q, light_cross);
      ys_viol    = ((prev_main_q == LAMP_Y) && (light_main == LAMP_R) &&
                    (ymain_q < YCW'(YEL_MIN_CYC))) ||
                   ((prev_cross_q == LAMP_Y) && (light_cross == LAMP_R) &&
                    (ycross_q < YCW'(YEL_MIN_CYC)));
      yl_viol    = ((light_main == LAMP_Y) && (ymain_q == YCW'(YEL_MAX_CYC))) ||
                   ((light_cross == LAMP_Y) && (ycross_q == YCW'(YEL_MAX_CYC)));
      safe_pat   = ((light_main == LAMP_R) && (light_cross == LAMP_G)) ||
                   ((light_main == LAMP_G) && (light_cross == LAMP_R));
      stable_pat = (light_main == prev_main_q) && (light_cross == prev_cross_q);

      // Lowest code wins when several checks fire together.
      code_arm = CODE_NONE;
      if (enc_viol)       code_arm = CODE_ENC;
      else if (conf_viol) code_arm = CODE_CONFLICT;

      code_mon = code_arm;
      if (code_arm == CODE_NONE) begin
         if (seq_viol)      code_mon = CODE_SEQ;
         else if (ys_viol)  code_mon = CODE_YEL_SHORT;
         else if (yl_viol)  code_mon = CODE_YEL_LONG;
      end
   end

   // Per-side yellow dwell counters: 1 on entry, saturating count while held.
   always_comb begin
      ymain_d  = '0;
      ycross_d = '0;
      if (light_main == LAMP_Y) begin
         if (prev_main_q != LAMP_Y)                 ymain_d = YCW'(1);
         else if (ymain_q < YCW'(YEL_MAX_CYC))      ymain_d = ymain_q + YCW'(1);
         else                                       ymain_d = ymain_q;
      end
      if (light_cross == LAMP_Y) begin
         if (prev_cross_q != LAMP_Y)                ycross_d = YCW'(1);
         else if (ycross_q < YCW'(YEL_MAX_CYC))     ycross_d = ycross_q + YCW'(1);
         else                                       ycross_d = ycross_q;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      arm_cnt_d   = arm_cnt_q;
      flash_cnt_d = flash_cnt_q;
      flash_d     = flash_q;
      code_d      = code_q;

      unique case (state_q)
         ST_ARM: begin
            if (code_arm != CODE_NONE) begin
               state_d     = ST_FAULT;
               code_d      = code_arm;
               flash_d     = 1'b1;
               flash_cnt_d = '0;
               arm_cnt_d   = '0;
            end else if ((arm_cnt_q == ACW'(ARM_CYC - 1)) && safe_pat) begin
               state_d   = ST_MONITOR;
               arm_cnt_d = '0;
            end else if (safe_pat && stable_pat) begin
               arm_cnt_d = arm_cnt_q + ACW'(1);
            end else begin
               arm_cnt_d = '0;
            end
         end
         ST_MONITOR: begin
            if (code_mon != CODE_NONE) begin
               state_d     = ST_FAULT;
               code_d      = code_mon;
               flash_d     = 1'b1;
               flash_cnt_d = '0;
            end
         end
         ST_FAULT: begin
            // Clear takes priority; violations are ignored while faulted.
            if (clear) begin
               state_d     = ST_ARM;
               code_d      = CODE_NONE;
               flash_d     = 1'b0;
               flash_cnt_d = '0;
               arm_cnt_d   = '0;
            end else if (flash_cnt_q == FCW'(FLASH_DIV - 1)) begin
               flash_cnt_d = '0;
               flash_d     = !flash_q;
            end else begin
               flash_cnt_d = flash_cnt_q + FCW'(1);
            end
         end
         default: begin
            state_d = ST_ARM;
         end
      endcase

      fault_d = (state_d == ST_FAULT);
      armed_d = (state_d == ST_MONITOR);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_ARM;
         prev_main_q  <= LAMP_G;
         prev_cross_q <= LAMP_R;
         ymain_q      <= '0;
         ycross_q     <= '0;
         arm_cnt_q    <= '0;
         flash_cnt_q  <= '0;
         flash_q      <= 1'b0;
         fault_q      <= 1'b0;
         armed_q      <= 1'b0;
         code_q       <= CODE_NONE;
      end else begin
         state_q      <= state_d;
         prev_main_q  <= light_main;
         prev_cross_q <= light_cross;
         ymain_q      <= ymain_d;
         ycross_q     <= ycross_d;
         arm_cnt_q    <= arm_cnt_d;
         flash_cnt_q  <= flash_cnt_d;
         flash_q      <= flash_d;
         fault_q      <= fault_d;
         armed_q      <= armed_d;
         code_q       <= code_d;
      end
   end

   assign fault      = fault_q;
   assign fault_code = code_q;
   assign flash      = flash_q;
   assign armed      = armed_q;

endmodule
